seq_right_rotator: RTL and testbench



---
 rtl/seq_right_rotator.sv | 89 ++++++++
 tb/tb_seq_right_rotator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_right_rotator.sv
// rtl/seq_right_rotator.sv - iterative right rotate / logical shift, one bit per clock
module seq_right_rotator #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [SEL_W-1:0] sel,
    input  logic             cntrl,
    output logic [WIDTH-1:0] z,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic [WIDTH-1:0] shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            z_q     <= z_d;
        end
    end

    // Rotate feeds the outgoing LSB back in at the MSB; shift feeds a zero.
    assign shifted = {(mode_q ? sh_q[0] : 1'b0), sh_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        z_d     = z_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sh_d   = x;
                    cnt_d  = sel;
                    mode_d = cntrl;
                    if (sel == '0) begin
                        z_d     = x;
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                sh_d  = shifted;
                cnt_d = cnt_q - SEL_W'(1);
                if (cnt_q == SEL_W'(1)) begin
                    z_d     = shifted;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
        z    = z_q;
    end

endmodule

// File: tb/tb_seq_right_rotator.sv
// tb/tb_seq_right_rotator.sv - self-checking bench for seq_right_rotator
module tb_seq_right_rotator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x = 8'h00;
    logic [2:0] sel = 3'd0;
    logic       cntrl = 1'b0;
    logic [7:0] z;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    seq_right_rotator #(.WIDTH(8), .SEL_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .sel   (sel),
        .cntrl (cntrl),
        .z     (z),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_op(input logic [7:0] a, input int s, input logic rot);
        logic [15:0] d;
        d = {a, a} >> s;
        return rot ? d[7:0] : (a >> s);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: an accepted op finishes sel+1 cycles later with ROR/LSR of x.
    int         m_left = 0;
    logic [7:0] m_res = 8'h00;
    logic [7:0] m_z = 8'h00;
    logic       m_done = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_z    <= 8'h00;
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_z    <= m_res;
            end else begin
                m_done <= 1'b0;
            end
        end else if (start) begin
            m_res <= ref_op(x, int'(sel), cntrl);
            if (sel == 3'd0) begin
                m_done <= 1'b1;
                m_z    <= ref_op(x, 0, cntrl);
            end else begin
                m_done <= 1'b0;
                m_left <= int'(sel);
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("cmp_z", 32'(z), 32'(m_z));
            check("cmp_busy", 32'(busy), 32'(m_left > 0));
            check("cmp_done", 32'(done), 32'(m_done));
        end
    end

    task automatic wait_done(input string name, output int lat);
        bit got;
        got = 0;
        lat = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (done) got = 1;
        end
        check({name, "_timeout"}, 32'(got), 32'd1);
    endtask

    task automatic run_op(input logic [7:0] xv, input int s, input logic c,
                          input logic [7:0] exp_z, input string name);
        int lat, bcnt;
        bit got;
        @(posedge clk); #2;
        x = xv; sel = 3'(s); cntrl = c; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        lat = 0; bcnt = 0; got = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (done) got = 1;
        end
        check({name, "_got"}, 32'(got), 32'd1);
        check({name, "_lat"}, 32'(lat), 32'(s + 1));
        check({name, "_busy_cycles"}, 32'(bcnt), 32'(s));
        check({name, "_z"}, 32'(z), 32'(exp_z));
        @(negedge clk);
        check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat, dcnt;

        check("model_ror3", 32'(ref_op(8'hCC, 3, 1'b1)), 32'h99);
        check("model_lsr3", 32'(ref_op(8'hCC, 3, 1'b0)), 32'h19);

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_z", 32'(z), 32'h00);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        chk_en = 1;

        run_op(8'b11001100, 3, 1'b1, 8'b10011001, "ror3");
        run_op(8'b11001100, 3, 1'b0, 8'b00011001, "lsr3");
        run_op(8'b11001100, 0, 1'b1, 8'b11001100, "sel0");
        run_op(8'b11001100, 7, 1'b1, 8'b10011001, "ror7");
        run_op(8'b11001100, 7, 1'b0, 8'b00000001, "lsr7");

        // start re-pulsed with new operands while shifting must be ignored
        @(posedge clk); #2;
        x = 8'hCC; sel = 3'd5; cntrl = 1'b1; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        x = 8'h0F; sel = 3'd1; cntrl = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; x = 8'h33;
        wait_done("ignore", lat);
        check("ignore_lat", 32'(lat), 32'd4);
        check("ignore_z", 32'(z), 32'h66);

        // asynchronous reset in the middle of a shift
        @(posedge clk); #2;
        x = 8'hCC; sel = 3'd7; cntrl = 1'b1; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        check("midrst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_z", 32'(z), 32'h00);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("midrst_no_done", 32'(dcnt), 32'd0);

        // back-to-back: start held through DONE
        @(posedge clk); #2;
        x = 8'hCC; sel = 3'd3; cntrl = 1'b1; start = 1'b1;
        @(posedge clk);
        wait_done("b2b_first", lat);
        check("b2b_first_lat", 32'(lat), 32'd4);
        check("b2b_first_z", 32'(z), 32'h99);
        x = 8'hFF; sel = 3'd1; cntrl = 1'b0;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done("b2b_second", lat);
        check("b2b_gap", 32'(lat), 32'd2);
        check("b2b_second_z", 32'(z), 32'h7F);
        @(negedge clk);

        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s < 8; s++) begin
                for (int v = 0; v < 256; v++) begin
                    run_op(8'(v), s, 1'(c), ref_op(8'(v), s, 1'(c)), "sweep");
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
